wb_arbiter: RTL and testbench

Shares the register file's single write port among the core's writeback sources: ALU pipe, load/store unit and mul/div unit. Each source offers a write through a valid/ready handshake. A round-robin arbiter grants one source per cycle, and the winning write is registered onto the register file's write port.

---
 rtl/core_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 51 +++++
 rtl/wb_arbiter.sv | 100 ++++++++++
 tb/tb_wb_arbiter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Core-wide constants shared by the writeback path and its arbiters.
package core_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  localparam int WB_SRC_ALU = 0;
  localparam int WB_SRC_LSU = 1;
  localparam int WB_SRC_MDU = 2;
  localparam int WB_NUM_SRC = 3;
  localparam int WB_NREQ    = WB_NUM_SRC;

  // Index width that stays legal for a single requester.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from the prio pointer upward.
// The pointer moves past the winner only when the caller reports advance.
module rr_arbiter
  import core_pkg::*;
#(
  parameter int NREQ = WB_NREQ,
  localparam int IW  = idx_width(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            advance,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   gnt_idx
);

  logic [IW-1:0] prio_q, prio_d;
  logic          found;
  int            cand;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = 0;
    for (int k = 0; k < NREQ; k++) begin
      cand = (int'(prio_q) + k) % NREQ;
      if (!found && req[IW'(cand)]) begin
        found            = 1'b1;
        gnt[IW'(cand)]   = 1'b1;
        gnt_idx          = IW'(cand);
      end
    end
  end

  always_comb begin
    prio_d = prio_q;
    if (advance) begin
      prio_d = (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + IW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prio_q <= '0;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: shares the register file write port among the ALU, LSU
// and MDU, registering the winning write for one cycle.
module wb_arbiter
  import core_pkg::*;
#(
  parameter int NREQ = WB_NREQ,
  parameter int XLEN = core_pkg::XLEN,
  parameter int AW   = REG_AW
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ-1:0][AW-1:0]   req_rd_addr,
  input  logic [NREQ-1:0][XLEN-1:0] req_rd_data,
  output logic                      rd_wren,
  output logic [AW-1:0]             rd_addr,
  output logic [XLEN-1:0]           rd_data,
  output logic [1:0]                wb_src,
  output logic                      gnt_any
);

  localparam int IW = idx_width(NREQ);

  logic [NREQ-1:0]           gnt;
  logic [IW-1:0]             gnt_idx;
  logic                      xfer;
  logic [NREQ-1:0][AW-1:0]   addr_masked;
  logic [NREQ-1:0][XLEN-1:0] data_masked;
  logic [AW-1:0]             sel_addr;
  logic [XLEN-1:0]           sel_data;

  logic            rd_wren_q, rd_wren_d;
  logic [AW-1:0]   rd_addr_q, rd_addr_d;
  logic [XLEN-1:0] rd_data_q, rd_data_d;
  logic [1:0]      wb_src_q, wb_src_d;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid),
    .advance (xfer),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // No handshake can complete while reset is held.
  assign req_ready = rst ? gnt : '0;
  assign xfer      = |req_ready;
  assign gnt_any   = xfer;

  // Grant is one-hot, so an AND-OR mux selects the winner's payload.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_mask
    assign addr_masked[gi] = gnt[gi] ? req_rd_addr[gi] : '0;
    assign data_masked[gi] = gnt[gi] ? req_rd_data[gi] : '0;
  end

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      sel_addr = sel_addr | addr_masked[i];
      sel_data = sel_data | data_masked[i];
    end
  end

  always_comb begin
    rd_wren_d = 1'b0;
    rd_addr_d = rd_addr_q;
    rd_data_d = rd_data_q;
    wb_src_d  = wb_src_q;
    if (xfer) begin
      // x0 writes are consumed but never reach the register file.
      rd_wren_d = (sel_addr != '0);
      rd_addr_d = sel_addr;
      rd_data_d = sel_data;
      wb_src_d  = 2'(gnt_idx);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_wren_q <= 1'b0;
      rd_addr_q <= '0;
      rd_data_q <= '0;
      wb_src_q  <= '0;
    end else begin
      rd_wren_q <= rd_wren_d;
      rd_addr_q <= rd_addr_d;
      rd_data_q <= rd_data_d;
      wb_src_q  <= wb_src_d;
    end
  end

  assign rd_wren = rd_wren_q;
  assign rd_addr = rd_addr_q;
  assign rd_data = rd_data_q;
  assign wb_src  = wb_src_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Table-driven bench for wb_arbiter with a scoreboard of expected port writes.
module tb_wb_arbiter;

  logic             clk;
  logic             rst;
  logic [2:0]       req_valid;
  logic [2:0]       req_ready;
  logic [2:0][4:0]  req_rd_addr;
  logic [2:0][31:0] req_rd_data;
  logic             rd_wren;
  logic [4:0]       rd_addr;
  logic [31:0]      rd_data;
  logic [1:0]       wb_src;
  logic             gnt_any;

  typedef struct packed {
    logic [2:0]       v;
    logic [2:0][4:0]  a;
    logic [2:0][31:0] d;
    logic [2:0]       rdy;
  } vec_t;

  typedef struct packed {
    logic        wren;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [1:0]  src;
  } out_t;

  localparam int NVEC = 18;

  vec_t tbl [NVEC];
  out_t sb_q [$];
  out_t model;
  int   n_checks = 0;
  int   n_fail   = 0;

  wb_arbiter #(.NREQ(3), .XLEN(32), .AW(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_rd_addr (req_rd_addr),
    .req_rd_data (req_rd_data),
    .rd_wren     (rd_wren),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .wb_src      (wb_src),
    .gnt_any     (gnt_any)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "timeout");
  end

  // Stimulus sanity: a waiting source keeps valid, addr and data stable.
  logic [2:0]       pend_q;
  logic [2:0][4:0]  pend_a_q;
  logic [2:0][31:0] pend_d_q;
  always @(posedge clk) begin
    if (!rst) begin
      pend_q <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (pend_q[i]) begin
          assert (req_valid[i] && req_rd_addr[i] == pend_a_q[i] && req_rd_data[i] == pend_d_q[i])
            else $error("source %0d dropped or changed a pending write", i);
        end
      end
      pend_q   <= req_valid & ~req_ready;
      pend_a_q <= req_rd_addr;
      pend_d_q <= req_rd_data;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] v,
                              input logic [4:0] a0, input logic [31:0] d0,
                              input logic [4:0] a1, input logic [31:0] d1,
                              input logic [4:0] a2, input logic [31:0] d2,
                              input logic [2:0] rdy);
    vec_t t;
    t.v = v;
    t.a[0] = a0; t.d[0] = d0;
    t.a[1] = a1; t.d[1] = d1;
    t.a[2] = a2; t.d[2] = d2;
    t.rdy = rdy;
    return t;
  endfunction

  // Entered just after a rising edge; returns just after the next one.
  task automatic run_vec(input vec_t t, input int n);
    out_t e;
    req_valid   = t.v;
    req_rd_addr = t.a;
    req_rd_data = t.d;
    #1;
    chk($sformatf("vec%0d req_ready", n), 64'(req_ready), 64'(t.rdy));
    chk($sformatf("vec%0d gnt_any", n), 64'(gnt_any), 64'(|t.rdy));
    e = model;
    e.wren = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (t.rdy[i]) begin
        e.wren = (t.a[i] != 5'd0);
        e.addr = t.a[i];
        e.data = t.d[i];
        e.src  = 2'(i);
      end
    end
    model = e;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk($sformatf("vec%0d rd_wren", n), 64'(rd_wren), 64'(e.wren));
    chk($sformatf("vec%0d rd_addr", n), 64'(rd_addr), 64'(e.addr));
    chk($sformatf("vec%0d rd_data", n), 64'(rd_data), 64'(e.data));
    chk($sformatf("vec%0d wb_src", n), 64'(wb_src), 64'(e.src));
    $display("vec %0d valid=%b ready=%b -> rd_wren=%b rd_addr=%0d rd_data=%h wb_src=%0d",
             n, t.v, t.rdy, rd_wren, rd_addr, rd_data, wb_src);
  endtask

  initial begin
    tbl[0]  = mk(3'b111, 5'd1, 32'h11,   5'd2, 32'h22,       5'd3, 32'h33, 3'b001);
    tbl[1]  = mk(3'b110, 5'd0, 32'h0,    5'd2, 32'h22,       5'd3, 32'h33, 3'b010);
    tbl[2]  = mk(3'b100, 5'd0, 32'h0,    5'd0, 32'h0,        5'd3, 32'h33, 3'b100);
    tbl[3]  = mk(3'b001, 5'd1, 32'h111,  5'd0, 32'h0,        5'd0, 32'h0,  3'b001);
    tbl[4]  = mk(3'b010, 5'd0, 32'h0,    5'd10, 32'hDEADBEEF, 5'd0, 32'h0, 3'b010);
    tbl[5]  = mk(3'b000, 5'd0, 32'h0,    5'd0, 32'h0,        5'd0, 32'h0,  3'b000);
    tbl[6]  = mk(3'b100, 5'd0, 32'h0,    5'd0, 32'h0,        5'd7, 32'h77, 3'b100);
    tbl[7]  = mk(3'b101, 5'd8, 32'h88,   5'd0, 32'h0,        5'd9, 32'h99, 3'b001);
    tbl[8]  = mk(3'b100, 5'd0, 32'h0,    5'd0, 32'h0,        5'd9, 32'h99, 3'b100);
    tbl[9]  = mk(3'b001, 5'd0, 32'h1234, 5'd0, 32'h0,        5'd0, 32'h0,  3'b001);
    tbl[10] = mk(3'b101, 5'd4, 32'h44,   5'd0, 32'h0,        5'd6, 32'h66, 3'b100);
    tbl[11] = mk(3'b001, 5'd4, 32'h44,   5'd0, 32'h0,        5'd0, 32'h0,  3'b001);
    tbl[12] = mk(3'b000, 5'd0, 32'h0,    5'd0, 32'h0,        5'd0, 32'h0,  3'b000);
    tbl[13] = mk(3'b000, 5'd0, 32'h0,    5'd0, 32'h0,        5'd0, 32'h0,  3'b000);
    tbl[14] = mk(3'b000, 5'd0, 32'h0,    5'd0, 32'h0,        5'd0, 32'h0,  3'b000);
    tbl[15] = mk(3'b011, 5'd12, 32'hA,   5'd12, 32'hB,       5'd0, 32'h0,  3'b010);
    tbl[16] = mk(3'b001, 5'd12, 32'hA,   5'd0, 32'h0,        5'd0, 32'h0,  3'b001);
    tbl[17] = mk(3'b000, 5'd0, 32'h0,    5'd0, 32'h0,        5'd0, 32'h0,  3'b000);

    model       = '0;
    rst         = 1'b0;
    req_valid   = 3'b111;
    req_rd_addr = '0;
    req_rd_data = '0;

    // Reset state, with requests present that must not be acknowledged.
    #3;
    chk("reset req_ready", 64'(req_ready), 64'(3'b000));
    chk("reset gnt_any", 64'(gnt_any), 64'(1'b0));
    chk("reset rd_wren", 64'(rd_wren), 64'(1'b0));
    chk("reset rd_addr", 64'(rd_addr), 64'(5'd0));
    chk("reset rd_data", 64'(rd_data), 64'(32'd0));
    chk("reset wb_src", 64'(wb_src), 64'(2'd0));
    req_valid = 3'b000;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    for (int n = 0; n < NVEC; n++) begin
      run_vec(tbl[n], n);
    end

    // Reset asserted mid-cycle with a write already registered.
    req_valid      = 3'b001;
    req_rd_addr[0] = 5'd5;
    req_rd_data[0] = 32'h55;
    #1;
    chk("mid ready before reset", 64'(req_ready), 64'(3'b001));
    @(posedge clk);
    #1;
    chk("mid rd_wren registered", 64'(rd_wren), 64'(1'b1));
    chk("mid rd_addr registered", 64'(rd_addr), 64'(5'd5));
    #2;
    rst = 1'b0;
    #1;
    chk("async reset rd_wren", 64'(rd_wren), 64'(1'b0));
    chk("async reset rd_addr", 64'(rd_addr), 64'(5'd0));
    chk("async reset rd_data", 64'(rd_data), 64'(32'd0));
    chk("async reset wb_src", 64'(wb_src), 64'(2'd0));
    chk("async reset req_ready", 64'(req_ready), 64'(3'b000));
    chk("async reset gnt_any", 64'(gnt_any), 64'(1'b0));
    $display("reset asserted mid-traffic: rd_wren=%b req_ready=%b", rd_wren, req_ready);
    @(posedge clk);
    #1;
    chk("held reset rd_wren", 64'(rd_wren), 64'(1'b0));
    chk("held reset req_ready", 64'(req_ready), 64'(3'b000));
    sb_q.delete();
    model     = '0;
    req_valid = 3'b000;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Pointer back at 0: ALU wins over LSU, LSU follows.
    run_vec(mk(3'b011, 5'd5, 32'h505, 5'd6, 32'h606, 5'd0, 32'h0, 3'b001), 100);
    run_vec(mk(3'b010, 5'd0, 32'h0,   5'd6, 32'h606, 5'd0, 32'h0, 3'b010), 101);
    run_vec(mk(3'b000, 5'd0, 32'h0,   5'd0, 32'h0,   5'd0, 32'h0, 3'b000), 102);

    chk("scoreboard drained", 64'(sb_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
